// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier with a valid/ready
// handshake. The exponent and fraction widths are parameters. Rounding is
// round-to-nearest-even. Subnormal inputs are treated as zero, and underflowing
// results are flushed to zero. The block reports overflow, underflow, inexact
// and invalid flags for each result.
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] opA,
    input  logic [EXP_W+MAN_W:0] opB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] product,
    output logic                 flag_overflow,
    output logic                 flag_underflow,
    output logic                 flag_inexact,
    output logic                 flag_invalid
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;          // significand width incl. hidden bit
    localparam int PW = 2 * SW;             // raw significand product width
    localparam int RW = SW + 1;             // rounded significand incl. carry-out
    localparam int XW = EXP_W + 2;          // signed working exponent width

    localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // ---------------- handshake ----------------
    logic w_advance;
    logic r3_valid;

    assign w_advance = ~r3_valid | out_ready;
    assign in_ready  = w_advance;

    // ---------------- stage 1: unpack / classify / multiply ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    cls_t             w_cls;
    logic [PW-1:0]    w_sig_prod;
    logic signed [XW-1:0] w_exp_sum;

    assign w_sa = opA[W-1];
    assign w_sb = opB[W-1];
    assign w_ea = opA[W-2:MAN_W];
    assign w_eb = opB[W-2:MAN_W];
    assign w_fa = opA[MAN_W-1:0];
    assign w_fb = opB[MAN_W-1:0];

    assign w_a_zero = ~|w_ea;
    assign w_b_zero = ~|w_eb;
    assign w_a_inf  = (&w_ea) & ~|w_fa;
    assign w_b_inf  = (&w_eb) & ~|w_fb;
    assign w_a_nan  = (&w_ea) & |w_fa;
    assign w_b_nan  = (&w_eb) & |w_fb;

    assign w_sig_prod = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});
    assign w_exp_sum  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

    // Resolve special-value class in priority order: invalid, infinity, zero.
    always_comb begin
        w_cls = CLS_NORM;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero))
            w_cls = CLS_NAN;
        else if (w_a_inf | w_b_inf)
            w_cls = CLS_INF;
        else if (w_a_zero | w_b_zero)
            w_cls = CLS_ZERO;
    end

    logic                 r1_valid;
    logic                 r1_sign;
    cls_t                 r1_cls;
    logic [PW-1:0]        r1_prod;
    logic signed [XW-1:0] r1_exp;

    // Stage 1 register: capture operands' class, raw product and exponent sum.
    always_ff @(posedge clock) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_cls   <= CLS_NORM;
            r1_prod  <= '0;
            r1_exp   <= '0;
        end else if (w_advance) begin
            r1_valid <= in_valid;
            r1_sign  <= w_sa ^ w_sb;
            r1_cls   <= w_cls;
            r1_prod  <= w_sig_prod;
            r1_exp   <= w_exp_sum;
        end
    end

    // ---------------- stage 2: normalise and round ----------------
    logic                 w_msb;
    logic [PW-2:0]        w_norm;
    logic                 w_lost;
    logic [SW-1:0]        w_sig;
    logic                 w_guard, w_sticky, w_round_up, w_carry;
    logic [RW-1:0]        w_rounded;
    logic [MAN_W-1:0]     w_frac;
    logic [XW-1:0]        w_exp_adj;
    logic signed [XW-1:0] w_exp2;

    assign w_msb      = r1_prod[PW-1];
    // After the one-bit right shift the top bit is always zero, so only PW-1
    // bits are kept; the bit shifted out joins the sticky term.
    assign w_norm     = w_msb ? r1_prod[PW-1:1] : r1_prod[PW-2:0];
    assign w_lost     = w_msb & r1_prod[0];
    assign w_sig      = w_norm[PW-2:MAN_W];
    assign w_guard    = w_norm[MAN_W-1];
    assign w_sticky   = (|w_norm[MAN_W-2:0]) | w_lost;
    assign w_round_up = w_guard & (w_sticky | w_sig[0]);
    assign w_rounded  = {1'b0, w_sig} + RW'(w_round_up);
    assign w_carry    = w_rounded[RW-1];
    assign w_frac     = w_carry ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
    assign w_exp_adj  = XW'(w_msb) + XW'(w_carry);
    assign w_exp2     = r1_exp + $signed(w_exp_adj);

    logic                 r2_valid;
    logic                 r2_sign;
    cls_t                 r2_cls;
    logic [MAN_W-1:0]     r2_frac;
    logic signed [XW-1:0] r2_exp;
    logic                 r2_inexact;

    // Stage 2 register: hold the rounded fraction and the adjusted exponent.
    always_ff @(posedge clock) begin
        if (reset) begin
            r2_valid   <= 1'b0;
            r2_sign    <= 1'b0;
            r2_cls     <= CLS_NORM;
            r2_frac    <= '0;
            r2_exp     <= '0;
            r2_inexact <= 1'b0;
        end else if (w_advance) begin
            r2_valid   <= r1_valid;
            r2_sign    <= r1_sign;
            r2_cls     <= r1_cls;
            r2_frac    <= w_frac;
            r2_exp     <= w_exp2;
            r2_inexact <= w_guard | w_sticky;
        end
    end

    // ---------------- stage 3: range check and pack ----------------
    logic [W-1:0] w_res;
    logic         w_ovf, w_unf, w_inx, w_inv;

    // Choose the packed result and its flags from the class and the exponent range.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = 1'b0;
        w_inv = 1'b0;
        unique case (r2_cls)
            CLS_NAN: begin
                w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_inv = 1'b1;
            end
            CLS_INF:  w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: w_res = {r2_sign, {(W-1){1'b0}}};
            CLS_NORM: begin
                if (r2_exp >= EXP_MAX) begin
                    w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_ovf = 1'b1;
                    w_inx = 1'b1;
                end else if (r2_exp <= EXP_ZERO) begin
                    w_res = {r2_sign, {(W-1){1'b0}}};
                    w_unf = 1'b1;
                    w_inx = 1'b1;
                end else begin
                    w_res = {r2_sign, r2_exp[EXP_W-1:0], r2_frac};
                    w_inx = r2_inexact;
                end
            end
        endcase
    end

    logic [W-1:0] r3_product;
    logic         r3_ovf, r3_unf, r3_inx, r3_inv;

    // Output register: holds the result stable while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r3_valid   <= 1'b0;
            r3_product <= '0;
            r3_ovf     <= 1'b0;
            r3_unf     <= 1'b0;
            r3_inx     <= 1'b0;
            r3_inv     <= 1'b0;
        end else if (w_advance) begin
            r3_valid   <= r2_valid;
            r3_product <= w_res;
            r3_ovf     <= w_ovf;
            r3_unf     <= w_unf;
            r3_inx     <= w_inx;
            r3_inv     <= w_inv;
        end
    end

    assign out_valid      = r3_valid;
    assign product        = r3_product;
    assign flag_overflow  = r3_ovf;
    assign flag_underflow = r3_unf;
    assign flag_inexact   = r3_inx;
    assign flag_invalid   = r3_inv;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: an fp16 instance and an fp32 instance,
// checked against a real-valued reference multiplier with RNE rounding and FTZ.
module tb_fp_mul_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // fp16 instance signals
    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, p16;
    logic        fo16, fu16, fx16, fi16;
    // fp32 instance signals
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, p32;
    logic        fo32, fu32, fx32, fi32;

    int errors = 0;
    int checks = 0;

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clock(clock), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .opA(a16), .opB(b16), .out_valid(ov16), .out_ready(or16),
        .product(p16), .flag_overflow(fo16), .flag_underflow(fu16),
        .flag_inexact(fx16), .flag_invalid(fi16)
    );

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clock(clock), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .opA(a32), .opB(b32), .out_valid(ov32), .out_ready(or32),
        .product(p32), .flag_overflow(fo32), .flag_underflow(fu32),
        .flag_inexact(fx32), .flag_invalid(fi32)
    );

    // Reference: decode to exact real values, multiply, round to nearest even.
    // Flags are packed {overflow, underflow, inexact, invalid}.
    function automatic void ref_mul(input int ew, input int mw,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output logic [3:0] fl);
        int     emax, bias, ea, eb, e2, biased;
        longint fa, fb, q, one;
        logic   s;
        bit     na, nb, ia, ib, za, zb;
        real    x, scaled, fl0, rem;
        emax = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        one  = longint'(1) << mw;
        s    = a[ew + mw] ^ b[ew + mw];
        ea   = int'(a >> mw) & emax;
        eb   = int'(b >> mw) & emax;
        fa   = longint'(a) & (one - 1);
        fb   = longint'(b) & (one - 1);
        na = (ea == emax) && (fa != 0);
        nb = (eb == emax) && (fb != 0);
        ia = (ea == emax) && (fa == 0);
        ib = (eb == emax) && (fb == 0);
        za = (ea == 0);
        zb = (eb == 0);
        p  = '0;
        fl = '0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            p  = (32'(emax) << mw) | (32'd1 << (mw - 1));
            fl = 4'b0001;
        end else if (ia || ib) begin
            p = (32'(s) << (ew + mw)) | (32'(emax) << mw);
        end else if (za || zb) begin
            p = 32'(s) << (ew + mw);
        end else begin
            x  = real'(one + fa) * real'(one + fb);
            e2 = ea + eb - 2 * bias - 2 * mw;
            while (x >= 2.0) begin
                x = x / 2.0;
                e2++;
            end
            scaled = (x - 1.0) * real'(one);
            fl0    = $floor(scaled);
            rem    = scaled - fl0;
            q      = longint'(fl0);
            if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
            biased = e2 + bias;
            if (q == one) begin
                q = 0;
                biased++;
            end
            if (biased >= emax) begin
                p  = (32'(s) << (ew + mw)) | (32'(emax) << mw);
                fl = 4'b1010;
            end else if (biased <= 0) begin
                p  = 32'(s) << (ew + mw);
                fl = 4'b0110;
            end else begin
                p  = (32'(s) << (ew + mw)) | (32'(biased) << mw) | 32'(q);
                fl = {2'b00, rem != 0.0, 1'b0};
            end
        end
    endfunction

    function automatic logic [15:0] rand16();
        logic [15:0] v;
        int          r;
        v = 16'($urandom);
        r = $urandom_range(0, 15);
        if (r < 10)       v[14:10] = 5'($urandom_range(9, 21));
        else if (r == 10) v[14:10] = 5'h00;
        else if (r == 11) v[14:10] = 5'h1F;
        return v;
    endfunction

    function automatic logic [31:0] rand32_normal();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(100, 154));
        else                           v[30:23] = 8'($urandom_range(1, 254));
        return v;
    endfunction

    // Issue one fp16 op with out_ready high; lat counts falling edges until out_valid.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] p, output logic [3:0] f, output int lat);
        @(negedge clock);
        or16 = 1'b1;
        iv16 = 1'b1;
        a16  = a;
        b16  = b;
        @(negedge clock);
        iv16 = 1'b0;
        lat  = 1;
        while (!ov16 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        p = p16;
        f = {fo16, fu16, fx16, fi16};
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] p, output logic [3:0] f, output int lat);
        @(negedge clock);
        or32 = 1'b1;
        iv32 = 1'b1;
        a32  = a;
        b32  = b;
        @(negedge clock);
        iv32 = 1'b0;
        lat  = 1;
        while (!ov32 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        p = p32;
        f = {fo32, fu32, fx32, fi32};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset16_valid got %b want 0", ov16); end
        checks++; if (p16 !== 16'h0) begin errors++; $display("FAIL reset16_product got %h want 0000", p16); end
        checks++; if ({fo16, fu16, fx16, fi16} !== 4'b0) begin errors++; $display("FAIL reset16_flags got %b want 0000", {fo16, fu16, fx16, fi16}); end
        checks++; if (ov32 !== 1'b0 || p32 !== 32'h0) begin errors++; $display("FAIL reset32_out got v=%b p=%h want v=0 p=0", ov32, p32); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (ir16 !== 1'b1) begin errors++; $display("FAIL reset16_in_ready got %b want 1", ir16); end
        checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset32_in_ready got %b want 1", ir32); end
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset16_idle_valid got %b want 0", ov16); end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic [3:0]  f;
    } vec16_t;

    task automatic test_directed16();
        vec16_t      tbl [13];
        logic [15:0] p;
        logic [3:0]  f;
        int          lat;
        tbl = '{
            '{16'h3E00, 16'h4000, 16'h4200, 4'b0000},
            '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0010},
            '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0010},
            '{16'hBC00, 16'h3C00, 16'hBC00, 4'b0000},
            '{16'h7BFF, 16'h4000, 16'h7C00, 4'b1010},
            '{16'h0400, 16'h3800, 16'h0000, 4'b0110},
            '{16'h8400, 16'h3800, 16'h8000, 4'b0110},
            '{16'h7C00, 16'h0000, 16'h7E00, 4'b0001},
            '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000},
            '{16'h0001, 16'h4000, 16'h0000, 4'b0000},
            '{16'h7C01, 16'h3C00, 16'h7E00, 4'b0001},
            '{16'h7C00, 16'hFC00, 16'hFC00, 4'b0000},
            '{16'h8000, 16'h4500, 16'h8000, 4'b0000}
        };
        for (int i = 0; i < 13; i++) begin
            issue16(tbl[i].a, tbl[i].b, p, f, lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL dir16[%0d]_latency got %0d want 3", i, lat); end
            checks++; if (p !== tbl[i].p) begin errors++; $display("FAIL dir16[%0d]_product got %h want %h", i, p, tbl[i].p); end
            checks++; if (f !== tbl[i].f) begin errors++; $display("FAIL dir16[%0d]_flags got %b want %b", i, f, tbl[i].f); end
        end
    endtask

    task automatic test_backpressure16();
        logic [15:0] ops  [5];
        logic [15:0] want [5];
        logic [15:0] got_p [5];
        int          got_c [5];
        int          n_acc, got, extra;
        logic        acc;
        ops  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
        want = '{16'h4000, 16'h4400, 16'h4600, 16'h4800, 16'h4900};
        n_acc = 0;
        got   = 0;
        extra = 0;
        @(negedge clock);
        or16 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (n_acc < 5) begin iv16 = 1'b1; a16 = ops[n_acc]; b16 = 16'h4000; end
            else iv16 = 1'b0;
            #1 acc = iv16 && ir16;
            @(negedge clock);
            if (acc) n_acc++;
        end
        checks++; if (n_acc !== 3) begin errors++; $display("FAIL stall_accepts got %0d want 3", n_acc); end
        checks++; if (ir16 !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", ir16); end
        checks++; if (ov16 !== 1'b1 || p16 !== 16'h4000) begin errors++; $display("FAIL stall_hold got v=%b p=%h want v=1 p=4000", ov16, p16); end
        for (int c = 0; c < 20 && got < 5; c++) begin
            or16 = 1'b1;
            if (n_acc < 5) begin iv16 = 1'b1; a16 = ops[n_acc]; b16 = 16'h4000; end
            else iv16 = 1'b0;
            #1 acc = iv16 && ir16;
            if (ov16 && got < 5) begin
                got_p[got] = p16;
                got_c[got] = c;
                got++;
            end
            @(negedge clock);
            if (acc) n_acc++;
        end
        iv16 = 1'b0;
        checks++; if (got !== 5) begin errors++; $display("FAIL drain_count got %0d want 5", got); end
        for (int i = 0; i < got; i++) begin
            checks++; if (got_p[i] !== want[i]) begin errors++; $display("FAIL drain[%0d]_product got %h want %h", i, got_p[i], want[i]); end
        end
        if (got == 5) begin
            checks++; if (got_c[4] - got_c[0] !== 4) begin errors++; $display("FAIL drain_rate got span %0d want 4", got_c[4] - got_c[0]); end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (ov16) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL drain_duplicates got %0d extra want 0", extra); end
    endtask

    task automatic test_reset_flush16();
        logic [15:0] p;
        logic [3:0]  f;
        int          lat, stale;
        stale = 0;
        @(negedge clock);
        or16 = 1'b1;
        iv16 = 1'b1; a16 = 16'h3C00; b16 = 16'h4000;
        @(negedge clock);
        a16 = 16'h4000; b16 = 16'h4000;
        @(negedge clock);
        iv16  = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (ov16 !== 1'b0 || p16 !== 16'h0) begin errors++; $display("FAIL flush_out got v=%b p=%h want v=0 p=0000", ov16, p16); end
        checks++; if (ir16 !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", ir16); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (ov16) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale got %0d outputs want 0", stale); end
        issue16(16'h3E00, 16'h4000, p, f, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL flush_new_latency got %0d want 3", lat); end
        checks++; if (p !== 16'h4200 || f !== 4'b0) begin errors++; $display("FAIL flush_new_result got %h/%b want 4200/0000", p, f); end
    endtask

    task automatic test_random16();
        logic [19:0] q [$];
        logic [19:0] exp_v, act_v;
        logic [31:0] rp;
        logic [3:0]  rf;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            or16 = ($urandom_range(0, 9) < 7);
            iv16 = ($urandom_range(0, 9) < 7);
            a16  = rand16();
            b16  = rand16();
            #1;
            if (ov16 && or16) begin
                act_v = {p16, fo16, fu16, fx16, fi16};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand16_unexpected got %h with empty scoreboard", act_v);
                end else begin
                    exp_v = q.pop_front();
                    if (act_v !== exp_v) begin errors++; $display("FAIL rand16_result got %h want %h", act_v, exp_v); end
                end
            end
            if (iv16 && ir16) begin
                ref_mul(5, 10, {16'h0, a16}, {16'h0, b16}, rp, rf);
                q.push_back({rp[15:0], rf});
            end
        end
        @(negedge clock);
        iv16 = 1'b0;
        or16 = 1'b1;
        for (int c = 0; c < 30 && q.size() > 0; c++) begin
            #1;
            if (ov16) begin
                act_v = {p16, fo16, fu16, fx16, fi16};
                exp_v = q.pop_front();
                checks++; if (act_v !== exp_v) begin errors++; $display("FAIL rand16_drain got %h want %h", act_v, exp_v); end
            end
            @(negedge clock);
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand16_lost got %0d missing want 0", q.size()); end
    endtask

    task automatic test_param32();
        logic [31:0] a, b, p, rp;
        logic [3:0]  f, rf;
        int          lat;
        issue32(32'h3FC00000, 32'h40000000, p, f, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL fp32_basic_latency got %0d want 3", lat); end
        checks++; if (p !== 32'h40400000 || f !== 4'b0) begin errors++; $display("FAIL fp32_basic got %h/%b want 40400000/0000", p, f); end
        for (int i = 0; i < 60; i++) begin
            a = rand32_normal();
            b = rand32_normal();
            ref_mul(8, 23, a, b, rp, rf);
            issue32(a, b, p, f, lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL fp32_rand[%0d]_latency got %0d want 3", i, lat); end
            checks++; if (p !== rp) begin errors++; $display("FAIL fp32_rand[%0d]_product %h*%h got %h want %h", i, a, b, p, rp); end
            checks++; if (f !== rf) begin errors++; $display("FAIL fp32_rand[%0d]_flags got %b want %b", i, f, rf); end
        end
    endtask

    initial begin
        test_reset();
        test_directed16();
        test_backpressure16();
        test_reset_flush16();
        test_random16();
        test_param32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake. It generalises the combinational fp16 multiplier to any exponent and mantissa width, rounds to nearest even, and handles special values. It reports overflow, underflow, inexact and invalid flags per result. It sits in the GraphPulse processing datapath wherever event weights are scaled, and can absorb backpressure from the downstream consumer.

Parameters:
EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
MAN_W, 10, stored mantissa (fraction) width; hidden bit is implicit.
W, 1+EXP_W+MAN_W, total operand width; derived, not overridable.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  opA/opB are valid this cycle.
in_ready  out  1  block accepts operands this cycle.
opA  in  W  operand A {sign, exp, frac}.
opB  in  W  operand B.
out_valid  out  1  result fields are valid.
out_ready  in  1  consumer accepts the result this cycle.
product  out  W  rounded product.
flag_overflow  out  1  result overflowed to infinity.
flag_underflow  out  1  nonzero result flushed to zero.
flag_inexact  out  1  result differs from the exact product.
flag_invalid  out  1  invalid operation; result is canonical NaN.

Behaviour:
- Reset, sampled on a clock edge:
  - All stage valid bits clear.
  - out_valid=0; product and all flags = 0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight results. No partial output appears.
- Pipeline: 3 registered stages; latency 3 cycles from accept to out_valid with out_ready held high; throughput 1 per cycle.
  - S1: unpack, classify operands, multiply the (MAN_W+1)-bit significands, form the signed sum eA+eB-bias, and compute sign = sA^sB.
  - S2: normalise and round (described below).
  - S3: range check, pack, assert flags; drives the outputs.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - An input transfers when in_valid & in_ready.
  - When advance=0, every stage holds; outputs are stable while out_valid & !out_ready.
  - Bubbles propagate as invalid stages and never collapse. A fully stalled pipe holds exactly 3 results.
  - Results leave in input order.
- Operand classes:
  - exp==0: zero; subnormal inputs are treated as zero (DAZ).
  - exp all-ones & frac==0: infinity.
  - exp all-ones & frac!=0: NaN.
- Specials, in priority order:
  - Any NaN, or inf×zero: product = {0, all-ones exp, 1 followed by zeros}; flag_invalid=1.
  - inf×finite nonzero or inf×inf: signed infinity; no flags.
  - Zero×finite: signed zero; no flags.
- Normal path:
  - The significand product is 2*(MAN_W+1) bits. If its MSB is set, shift right by 1 and add 1 to the exponent.
  - Round to nearest even using guard = bit below the LSB and sticky = OR of all lower bits.
  - Round up when guard & (sticky | lsb).
  - If rounding carries out of the significand, renormalise and add 1 to the exponent.
  - inexact = guard | sticky.
  - The exponent path is EXP_W+2 bits signed, so no wrap is possible.
- Range:
  - Final biased exponent >= 2^EXP_W-1: signed infinity; flag_overflow=1, flag_inexact=1.
  - Final biased exponent <= 0: signed zero (FTZ); flag_underflow=1, flag_inexact=1.
  - Otherwise pack normally.
- Flags are only meaningful when out_valid=1 and are zero for special-value results except flag_invalid.

Test Plan:
- Basic (EXP_W=5, MAN_W=10): 0x3E00 × 0x4000 (1.5×2.0) -> 0x4200 exactly 3 cycles after accept; all flags 0.
- Rounding:
  - 0x3C01 × 0x3E00 (tie, lsb=1) -> 0x3E02, inexact=1.
  - 0x3C01 × 0x3C01 -> 0x3C02, inexact=1.
  - 0xBC00 × 0x3C00 -> 0xBC00, inexact=0.
- Range:
  - 0x7BFF × 0x4000 -> 0x7C00, overflow=1, inexact=1.
  - 0x0400 × 0x3800 -> 0x0000, underflow=1, inexact=1.
  - 0x8400 × 0x3800 -> 0x8000, underflow=1, inexact=1.
- Specials:
  - 0x7C00 × 0x0000 -> 0x7E00, invalid=1.
  - 0xFC00 × 0x4000 -> 0xFC00, no flags.
  - 0x0001 (subnormal) × 0x4000 -> 0x0000, no flags.
- Backpressure:
  - Hold out_ready=0 and push 5 back-to-back operands (A0..A4 = 1.0, 2.0, 3.0, 4.0, 5.0, each × 2.0).
  - in_ready drops after 3 accepts; product stays 0x4000 while stalled.
  - On releasing out_ready: 0x4000, 0x4400, 0x4600, 0x4800, 0x4900 appear in order, 1 per cycle, none lost or duplicated.
- Reset: assert reset for 1 cycle with 2 results in flight -> out_valid=0 the next cycle, no stale result ever emitted; a new op issued afterwards returns after 3 cycles.
- Parameter sweep: EXP_W=8, MAN_W=23: 0x3FC00000 × 0x40000000 -> 0x40400000; random normals checked against a real-valued model with RNE and FTZ.
